// File: rtl/adc_channel_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc_channel_sequencer
//  Purpose  : Round-robin command/response sequencer for the MAX 10 modular
//             ADC. Keeps one command outstanding and averages 2^AVG_LOG2
//             conversions per channel. Emits one sample per channel, tagged
//             with its index and an end-of-frame strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_channel_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int CH_BASE     = 1,
    parameter int DATA_W      = 12,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 256,
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              adc_locked,
    input  logic              clear_err,
    output logic              cmd_valid,
    output logic [4:0]        cmd_channel,
    input  logic              cmd_ready,
    input  logic              rsp_valid,
    input  logic [4:0]        rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done,
    output logic              err_mismatch,
    output logic              err_timeout
);

    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0]       C_CH_BASE  = 5'(CH_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [4:0]          cmd_channel_q, cmd_channel_d;
    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                frame_done_q, frame_done_d;
    logic                err_mis_q, err_mis_d;
    logic                err_tmo_q, err_tmo_d;

    logic                w_mis_ev;
    logic                w_tmo_ev;
    logic                w_rsp_hit;
    logic [ACC_W-1:0]    w_sum;

    // The commanded channel is held in cmd_channel_q for the whole WAIT phase.
    assign w_rsp_hit = rsp_valid && (rsp_channel == cmd_channel_q);
    assign w_sum     = acc_q + ACC_W'(rsp_data);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        tmo_d        = '0;
        out_valid_d  = 1'b0;
        out_index_d  = out_index_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        w_mis_ev     = 1'b0;
        w_tmo_ev     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && adc_locked) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An accepted command always gets its response window, even
                // if enable falls in the same cycle.
                if (!adc_locked) begin
                    state_d = ST_IDLE;
                end else if (cmd_valid_q && cmd_ready) begin
                    state_d = ST_WAIT;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!adc_locked) begin
                    state_d = ST_IDLE;
                end else if (rsp_valid) begin
                    state_d = enable ? ST_ISSUE : ST_IDLE;
                    if (w_rsp_hit) begin
                        if (cnt_q == C_CNT_LAST) begin
                            out_valid_d  = 1'b1;
                            out_index_d  = idx_q;
                            out_data_d   = w_sum[AVG_LOG2 +: DATA_W];
                            frame_done_d = (idx_q == C_IDX_LAST);
                            acc_d        = '0;
                            cnt_d        = '0;
                            idx_d        = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        end else begin
                            acc_d = w_sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        w_mis_ev = 1'b1;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    w_tmo_ev = 1'b1;
                    state_d  = enable ? ST_ISSUE : ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any return to IDLE drops the partial average and restarts at index 0.
        if (state_d == ST_IDLE) begin
            idx_d = '0;
            cnt_d = '0;
            acc_d = '0;
        end

        cmd_valid_d   = (state_d == ST_ISSUE);
        cmd_channel_d = C_CH_BASE + 5'(idx_d);
        err_mis_d     = (err_mis_q & ~clear_err) | w_mis_ev;
        err_tmo_d     = (err_tmo_q & ~clear_err) | w_tmo_ev;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            tmo_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= C_CH_BASE;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            out_data_q    <= '0;
            frame_done_q  <= 1'b0;
            err_mis_q     <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            tmo_q         <= tmo_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_channel_q <= cmd_channel_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            out_data_q    <= out_data_d;
            frame_done_q  <= frame_done_d;
            err_mis_q     <= err_mis_d;
            err_tmo_q     <= err_tmo_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_channel  = cmd_channel_q;
    assign out_valid    = out_valid_q;
    assign out_index    = out_index_q;
    assign out_data     = out_data_q;
    assign frame_done   = frame_done_q;
    assign err_mismatch = err_mis_q;
    assign err_timeout  = err_tmo_q;

endmodule
`default_nettype wire

// File: doc/adc_channel_sequencer.md
# adc_channel_sequencer

Parametrised multi-channel sequencer for the MAX 10 modular ADC Avalon-ST command/response interface. Round-robins over a contiguous range of ADC channels, keeps one command outstanding, optionally averages 2^AVG_LOG2 conversions per channel, and emits one averaged sample per channel with index and end-of-frame strobe. Sits between the ADC IP (clocked from the 10 MHz PLL output) and the FFT/sample-processing logic, replacing single-channel fixed-channel-0 capture.

## Interface

- NUM_CH, 4, number of channels scanned (1..8)
- CH_BASE, 1, ADC channel number of index 0; index i uses channel CH_BASE+i (CH_BASE+NUM_CH-1 ≤ 31)
- DATA_W, 12, ADC sample width
- AVG_LOG2, 2, log2 of conversions averaged per output (0..4; 0 = no averaging)
- TIMEOUT_CYC, 256, cycles in WAIT before reissuing (≥ 4)

- clk  in  1  ADC/system clock (PLL clock domain)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run scanning while high
- adc_locked  in  1  PLL locked; low aborts operation
- clear_err  in  1  synchronous clear of sticky error flags
- cmd_valid  out  1  command valid to ADC
- cmd_channel  out  5  ADC channel for current command
- cmd_ready  in  1  ADC accepts command
- rsp_valid  in  1  ADC response valid
- rsp_channel  in  5  channel of response
- rsp_data  in  DATA_W  conversion result
- out_valid  out  1  one-cycle strobe, new averaged sample
- out_index  out  clog2(NUM_CH) (min 1)  channel index of out_data
- out_data  out  DATA_W  averaged sample
- frame_done  out  1  one-cycle strobe with out_valid of index NUM_CH-1
- err_mismatch  out  1  sticky: response channel ≠ commanded channel
- err_timeout  out  1  sticky: no response within TIMEOUT_CYC

## Operation

- States: IDLE, ISSUE, WAIT.
- IDLE: cmd_valid=0; index, sample count, accumulator cleared. Enter ISSUE when enable && adc_locked.
- ISSUE: cmd_valid=1, cmd_channel=CH_BASE+index. On cmd_valid && cmd_ready → WAIT. cmd_channel stable while cmd_valid high.
- WAIT: cmd_valid=0; timeout counter runs.
  - rsp_valid && rsp_channel==cmd_channel: acc += rsp_data (acc width DATA_W+AVG_LOG2, cannot overflow); count++.
    - count not final → ISSUE, same index.
    - count final (2^AVG_LOG2 conversions) → out_data = (acc+rsp_data) >> AVG_LOG2 (truncate), out_valid=1, out_index=index; acc/count cleared; index increments, wrapping NUM_CH-1 → 0 with frame_done=1; → ISSUE.
  - rsp_valid with wrong channel: sample discarded, err_mismatch=1, → ISSUE same index, acc/count unchanged.
  - timeout counter reaches TIMEOUT_CYC-1 with no response: err_timeout=1, → ISSUE same index, acc/count unchanged.
- rsp_valid outside WAIT ignored (no flag).
- enable low: in ISSUE before handshake → IDLE next cycle; in WAIT → finish current response/timeout (accumulate, may emit output), then IDLE. Re-enable restarts at index 0.
- adc_locked low in any state: → IDLE next cycle, cmd_valid low, partial average discarded, no output.
- clear_err clears both flags; an error event in the same cycle wins (flag stays 1).

## Timing

- Reset values: cmd_valid=0, cmd_channel=CH_BASE, out_valid=0, out_index=0, out_data=0, frame_done=0, err_*=0; state IDLE.
- All outputs registered. cmd_valid rises the cycle after the enable&&adc_locked edge.
- Handshake edge → cmd_valid low the next cycle.
- Final response edge → out_valid/out_data/frame_done valid the next cycle (1-cycle latency), cmd_valid high in the same cycle (next command).
- Minimum per-conversion overhead: 1 cycle ISSUE (if cmd_ready high) + response latency.
- Single outstanding command; never issue while in WAIT.

## Test plan

- NUM_CH=4, CH_BASE=1, AVG_LOG2=0, cmd_ready=1, responses data=100*ch after 3 cycles → out sequence index 0..3 data 100,200,300,400; frame_done only with index 3; cmd_channel 1,2,3,4,1…
- AVG_LOG2=2, channel 1 responses 10,11,12,14 → one out_valid, out_data=11 (47>>2); averaging 4095×4 → 4095.
- Response with rsp_channel=7 while commanding 2 → err_mismatch=1, no out_valid, channel 2 reissued; clear_err → 0.
- No response for TIMEOUT_CYC=16 cycles → err_timeout=1 at cycle 16, cmd_valid reasserted for same channel; count preserved (AVG_LOG2=1: one good sample, timeout, one good → average of the two).
- cmd_ready held low 10 cycles → cmd_valid and cmd_channel held stable; enable dropped during stall → IDLE next cycle, re-enable starts at channel CH_BASE.
- adc_locked dropped in WAIT mid-average, late rsp_valid arrives → ignored, no output; reset asserted asynchronously mid-WAIT → all outputs to reset values immediately.
